// File: rtl/timebase_multi.sv
// Shared-period timebase with a shadowed period, a wrap strobe and N compare channels (pulse + PWM level).
// Optional prescaler and its `prescale` port are built in when TIMEBASE_PRESCALE_EN is defined.
module timebase_multi #(
    parameter int WIDTH          = 21,
    parameter int DEFAULT_PERIOD = 2000000,
    parameter int N_CMP          = 3,
    parameter int PRESCALE_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sync_clr,
    input  logic [WIDTH-1:0]       period_in,
    input  logic                   period_wr,
    input  logic [N_CMP*WIDTH-1:0] cmp_val,
`ifdef TIMEBASE_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]  prescale,
`endif
    output logic [WIDTH-1:0]       count,
    output logic                   wrap,
    output logic [N_CMP-1:0]       cmp_hit,
    output logic [N_CMP-1:0]       cmp_level,
    output logic                   period_pend
);

    localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] active_period_reg, active_period_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             pend_reg, pend_next;
    logic             wrap_reg, wrap_next;
    logic [N_CMP-1:0] hit_reg, hit_next;
    logic [N_CMP-1:0] level_reg, level_next;
    logic             advance;
    logic             moved;

`ifdef TIMEBASE_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_reg, presc_next;
    logic [PRESCALE_W-1:0] presc_lim_reg, presc_lim_next;
    logic [PRESCALE_W-1:0] presc_lim;

    // The divide ratio is latched at the start of each prescale run so mid-run changes cannot stretch it.
    always_comb begin
        presc_lim      = (presc_reg == '0) ? prescale : presc_lim_reg;
        advance        = enable && (presc_reg == presc_lim);
        presc_next     = presc_reg;
        presc_lim_next = presc_lim_reg;
        if (sync_clr) begin
            presc_next = '0;
        end else if (enable) begin
            presc_lim_next = presc_lim;
            presc_next     = advance ? '0 : presc_reg + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg     <= '0;
            presc_lim_reg <= '0;
        end else begin
            presc_reg     <= presc_next;
            presc_lim_reg <= presc_lim_next;
        end
    end
`else
    assign advance = enable;
`endif

    always_comb begin
        count_next         = count_reg;
        active_period_next = active_period_reg;
        shadow_next        = shadow_reg;
        pend_next          = pend_reg;
        wrap_next          = 1'b0;
        moved              = 1'b0;
        if (sync_clr) begin
            count_next = '0;
            moved      = 1'b1;
            if (pend_reg) begin
                active_period_next = shadow_reg;
            end
            pend_next = 1'b0;
        end else if (advance) begin
            moved = 1'b1;
            if (count_reg == active_period_reg - ONE) begin
                count_next = '0;
                wrap_next  = 1'b1;
                if (pend_reg) begin
                    active_period_next = shadow_reg;
                end
                pend_next = 1'b0;
            end else begin
                count_next = count_reg + ONE;
            end
        end
        // A write on the applying edge lands after the old shadow was consumed, so it waits for the next wrap.
        if (period_wr) begin
            shadow_next = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
            pend_next   = 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_cmp
        logic [WIDTH-1:0] cv;
        assign cv             = cmp_val[gi*WIDTH +: WIDTH];
        assign hit_next[gi]   = moved && (count_next == cv);
        assign level_next[gi] = (count_next < cv);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg         <= '0;
            active_period_reg <= DEF_PERIOD;
            shadow_reg        <= DEF_PERIOD;
            pend_reg          <= 1'b0;
            wrap_reg          <= 1'b0;
            hit_reg           <= '0;
            level_reg         <= '1;
        end else begin
            count_reg         <= count_next;
            active_period_reg <= active_period_next;
            shadow_reg        <= shadow_next;
            pend_reg          <= pend_next;
            wrap_reg          <= wrap_next;
            hit_reg           <= hit_next;
            level_reg         <= level_next;
        end
    end

    assign count       = count_reg;
    assign wrap        = wrap_reg;
    assign cmp_hit     = hit_reg;
    assign cmp_level   = level_reg;
    assign period_pend = pend_reg;

endmodule
